// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter slice.
// State encoding and requester port indices.
package mem_arb_pkg;
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;
endpackage

// File: rtl/mem_data.sv
// Single-port data memory.
// Reads are asynchronous; writes land on posedge.
module mem_data #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [p_ADDR_LEN-1:0] i_addr,
  input  logic [p_WORD_LEN-1:0] i_wr_data,
  output logic [p_WORD_LEN-1:0] o_rd_data
);
  logic [p_WORD_LEN-1:0] mem [2**p_ADDR_LEN];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_addr];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// One-hot grant; last_grant moves on every grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Starts at 1 so port 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end
endmodule

// File: rtl/mem_data_arbiter.sv
// Arbitrates CPU and debug ports onto one data memory.
// Optional zero-fill after reset; registered read responses.
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int p_WORD_LEN       = 16,
  parameter int p_ADDR_LEN       = 10,
  parameter int p_CLEAR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic [p_ADDR_LEN-1:0] i_req0_addr,
  input  logic [p_WORD_LEN-1:0] i_req0_wdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic [p_ADDR_LEN-1:0] i_req1_addr,
  input  logic [p_WORD_LEN-1:0] i_req1_wdata,
  output logic                  o_rsp0_valid,
  output logic [p_WORD_LEN-1:0] o_rsp0_rdata,
  output logic                  o_rsp1_valid,
  output logic [p_WORD_LEN-1:0] o_rsp1_rdata,
  output logic                  o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
  output logic                  o_busy_clear
);
  localparam int CW = p_ADDR_LEN + 1;
  localparam logic [CW-1:0] LAST_CNT =
    CW'((2**p_ADDR_LEN) - 1);
  localparam arb_state_t RST_ST =
    (p_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          clr;
  logic          rd0;
  logic          rd1;

  assign clr = (state == ST_CLEAR);
  assign req = {i_req1_valid, i_req0_valid};

  rr_arb2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req   (req),
    .en    (!clr),
    .gnt   (gnt)
  );

  assign o_req0_ready = gnt[PORT_CPU];
  assign o_req1_ready = gnt[PORT_DBG];
  assign o_busy_clear = clr;
  assign rd0 = gnt[PORT_CPU] && !i_req0_we;
  assign rd1 = gnt[PORT_DBG] && !i_req1_we;

  always_comb begin
    o_mem_wr_en   = 1'b0;
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    unique case (1'b1)
      clr: begin
        o_mem_wr_en = 1'b1;
        o_mem_addr  = cnt[p_ADDR_LEN-1:0];
      end
      gnt[PORT_CPU]: begin
        o_mem_wr_en   = i_req0_we;
        o_mem_addr    = i_req0_addr;
        o_mem_wr_data = i_req0_wdata;
      end
      gnt[PORT_DBG]: begin
        o_mem_wr_en   = i_req1_we;
        o_mem_addr    = i_req1_addr;
        o_mem_wr_data = i_req1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= RST_ST;
      cnt          <= '0;
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp0_rdata <= '0;
      o_rsp1_rdata <= '0;
    end else begin
      if (clr) begin
        cnt <= cnt + CW'(1);
        if (cnt == LAST_CNT) state <= ST_RUN;
      end
      o_rsp0_valid <= rd0;
      o_rsp1_valid <= rd1;
      if (rd0) o_rsp0_rdata <= i_mem_rd_data;
      if (rd1) o_rsp1_rdata <= i_mem_rd_data;
    end
  end
endmodule
